// File: rtl/paint_brush_ctrl.sv
// Brush and cursor controller: moves a cursor on the cell canvas from joystick ticks
// and stamps a square brush into the framebuffer as a stream of single-cell writes.
module paint_brush_ctrl #(
    parameter int TICK_DIV = 1_000_000,
    parameter int CENTER   = 512,
    parameter int DEAD     = 64,
    parameter int COLS     = 160,
    parameter int ROWS     = 120
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        tool_on,
    input  logic        tool_sel,
    input  logic        size_sel,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic        fb_data,
    output logic [7:0]  cur_x,
    output logic [6:0]  cur_y,
    output logic        tool,
    output logic [3:0]  size,
    output logic        busy
);

    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [9:0]    HI      = 10'(CENTER + DEAD);
    localparam logic [9:0]    LO      = 10'(CENTER - DEAD);
    localparam logic [7:0]    X_MAX   = 8'(COLS - 1);
    localparam logic [6:0]    Y_MAX   = 7'(ROWS - 1);
    localparam logic [7:0]    X_HOME  = 8'(COLS / 2);
    localparam logic [6:0]    Y_HOME  = 7'(ROWS / 2);

    typedef enum logic {
        IDLE  = 1'b0,
        STAMP = 1'b1
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic          tick;

    logic          tool_q, size_q;
    logic          tool_rise, size_rise;

    logic [7:0]    nx;
    logic [6:0]    ny;

    logic [7:0]    ox;
    logic [6:0]    oy;
    logic [3:0]    s;
    logic          wdata;
    logic [3:0]    i, j;

    logic [8:0]    cell_x, cell_y;
    logic          in_bounds;
    logic [14:0]   cell_addr;
    logic          last_i, last_j;

    logic          move, start, advance;

    // Free-running movement tick, independent of the FSM state.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

    assign tool_rise = tool_sel & ~tool_q;
    assign size_rise = size_sel & ~size_q;

    // Saturating next cursor; stick up (high Y) moves the cursor toward row 0.
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        if (x_pos > HI && cur_x != X_MAX) begin
            nx = cur_x + 8'd1;
        end else if (x_pos < LO && cur_x != 8'd0) begin
            nx = cur_x - 8'd1;
        end
        if (y_pos > HI && cur_y != 7'd0) begin
            ny = cur_y - 7'd1;
        end else if (y_pos < LO && cur_y != Y_MAX) begin
            ny = cur_y + 7'd1;
        end
    end

    // Offsets are widened before the bound compare so ox+i never wraps.
    assign cell_x    = {1'b0, ox} + {5'b0, i};
    assign cell_y    = {2'b0, oy} + {5'b0, j};
    assign in_bounds = (cell_x < 9'(COLS)) && (cell_y < 9'(ROWS));
    assign cell_addr = 15'(cell_y) * 15'(COLS) + 15'(cell_x);
    assign last_i    = (i == s - 4'd1);
    assign last_j    = (j == s - 4'd1);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        move       = 1'b0;
        start      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    move = 1'b1;
                    if (tool_on) begin
                        start      = 1'b1;
                        state_next = STAMP;
                    end
                end
            end
            STAMP: begin
                // Clipped cells cost one cycle; in-bounds cells wait for the handshake.
                advance = ~in_bounds | fb_ready;
                if (advance && last_i && last_j) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            tool_q <= 1'b0;
            size_q <= 1'b0;
            tool   <= 1'b0;
            size   <= 4'd1;
            cur_x  <= X_HOME;
            cur_y  <= Y_HOME;
            ox     <= '0;
            oy     <= '0;
            s      <= 4'd1;
            wdata  <= 1'b0;
            i      <= '0;
            j      <= '0;
        end else begin
            tool_q <= tool_sel;
            size_q <= size_sel;
            if (tool_rise) begin
                tool <= ~tool;
            end
            if (size_rise) begin
                size <= (size == 4'd8) ? 4'd1 : {size[2:0], 1'b0};
            end
            if (move) begin
                cur_x <= nx;
                cur_y <= ny;
            end
            // Brush parameters are frozen here so mid-stamp control changes wait for the next stamp.
            if (start) begin
                ox    <= nx;
                oy    <= ny;
                s     <= size;
                wdata <= ~tool;
                i     <= '0;
                j     <= '0;
            end else if (advance) begin
                if (last_i) begin
                    i <= '0;
                    j <= j + 4'd1;
                end else begin
                    i <= i + 4'd1;
                end
            end
        end
    end

    assign busy    = (state == STAMP);
    assign fb_we   = busy & in_bounds;
    assign fb_addr = fb_we ? cell_addr : 15'd0;
    assign fb_data = fb_we & wdata;

endmodule
